sevenseg_scan_capture: RTL



---
 rtl/sevenseg_scan_capture.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_capture.sv
// Receive side of a multiplexed seven-segment display: synchronises the scan lines,
// waits for a stable one-hot strobe and decodes each digit back to a hex nibble.
// Optional macro SEVENSEG_SCAN_CAPTURE_TIMEOUT_EN adds stale_o and a data-age timeout.
module sevenseg_scan_capture #(
   parameter int NDIG    = 4,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1000000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n,
   input  logic [7:0]          seg_i,
   input  logic [NDIG-1:0]     dig_i,
   input  logic                err_clr_i,
`ifdef SEVENSEG_SCAN_CAPTURE_TIMEOUT_EN
   output logic                stale_o,
`endif
   output logic [4*NDIG-1:0]   digits_o,
   output logic [NDIG-1:0]     dp_o,
   output logic [NDIG-1:0]     valid_o,
   output logic                frame_o,
   output logic                err_o
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [7:0]          seg_s1_q, seg_s2_q, ss_prev_q;
   logic [NDIG-1:0]     dig_s1_q, dig_s2_q, sd_prev_q;
   logic [4*NDIG-1:0]   digits_q, digits_d;
   logic [NDIG-1:0]     dp_q, dp_d;
   logic [NDIG-1:0]     valid_q, valid_d;
   logic [NDIG-1:0]     mask_q, mask_d;
   logic                err_q, err_d;

   logic [7:0]          ss;
   logic [NDIG-1:0]     sd;
   logic                onehot, sd_chg, ss_chg;
   logic                start, settle_done, cap, new_err;
   logic [4:0]          dec;

   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h3F:   return {1'b1, 4'h0};
         7'h06:   return {1'b1, 4'h1};
         7'h5B:   return {1'b1, 4'h2};
         7'h4F:   return {1'b1, 4'h3};
         7'h66:   return {1'b1, 4'h4};
         7'h6D:   return {1'b1, 4'h5};
         7'h7D:   return {1'b1, 4'h6};
         7'h07:   return {1'b1, 4'h7};
         7'h7F:   return {1'b1, 4'h8};
         7'h6F:   return {1'b1, 4'h9};
         7'h77:   return {1'b1, 4'hA};
         7'h7C:   return {1'b1, 4'hB};
         7'h39:   return {1'b1, 4'hC};
         7'h5E:   return {1'b1, 4'hD};
         7'h79:   return {1'b1, 4'hE};
         7'h71:   return {1'b1, 4'hF};
         default: return 5'h00;
      endcase
   endfunction

   // Two-flop synchroniser plus a delayed copy used for change detection.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         seg_s1_q  <= '0;
         seg_s2_q  <= '0;
         ss_prev_q <= '0;
         dig_s1_q  <= '0;
         dig_s2_q  <= '0;
         sd_prev_q <= '0;
      end else begin
         seg_s1_q  <= seg_i;
         seg_s2_q  <= seg_s1_q;
         ss_prev_q <= seg_s2_q;
         dig_s1_q  <= dig_i;
         dig_s2_q  <= dig_s1_q;
         sd_prev_q <= dig_s2_q;
      end
   end

   assign ss     = seg_s2_q;
   assign sd     = dig_s2_q;
   assign onehot = (sd != '0) && ((sd & (sd - NDIG'(1))) == '0);
   assign sd_chg = (sd != sd_prev_q);
   assign ss_chg = (ss != ss_prev_q);

   // The first one-hot cycle already counts as one stable cycle, so capture
   // lands SETTLE cycles after the synchronised strobe appears.
   assign start       = onehot && ((state_q == S_IDLE) || ((state_q == S_HOLD) && sd_chg));
   assign settle_done = (state_q == S_SETTLE) && !sd_chg && !ss_chg &&
                        (cnt_q == CW'(SETTLE - 1));
   assign cap         = (start && (SETTLE == 1)) || settle_done;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (start) begin
               state_d = (SETTLE == 1) ? S_HOLD : S_SETTLE;
               cnt_d   = CW'(1);
            end else if (state_q == S_HOLD && sd_chg) begin
               state_d = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (sd_chg) begin
               state_d = onehot ? S_SETTLE : S_IDLE;
               cnt_d   = CW'(1);
            end else if (ss_chg) begin
               cnt_d = CW'(1);
            end else if (settle_done) begin
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SEVENSEG_SCAN_CAPTURE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          stale_q, stale_d;
   logic          tmo_hit;

   assign tmo_hit = !cap && (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      tmo_d   = tmo_q;
      stale_d = stale_q;
      if (cap) begin
         tmo_d   = '0;
         stale_d = 1'b0;
      end else begin
         if (tmo_q != TW'(TIMEOUT))
            tmo_d = tmo_q + TW'(1);
         if (tmo_hit)
            stale_d = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         tmo_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         stale_q <= stale_d;
      end
   end

   assign stale_o = stale_q;
`endif

   assign dec = seg_decode(ss[6:0]);

   // Capture datapath: only the slot selected by the one-hot strobe is written.
   always_comb begin
      digits_d = digits_q;
      dp_d     = dp_q;
      valid_d  = valid_q;
      mask_d   = (&mask_q) ? '0 : mask_q;
      err_d    = err_q;
      new_err  = 1'b0;
      if (cap) begin
         for (int i = 0; i < NDIG; i++) begin
            if (sd[i]) begin
               dp_d[i]   = ss[7];
               mask_d[i] = 1'b1;
               if (dec[4]) begin
                  digits_d[4*i +: 4] = dec[3:0];
                  valid_d[i]         = 1'b1;
               end else if (ss[6:0] == 7'h00) begin
                  digits_d[4*i +: 4] = 4'h0;
                  valid_d[i]         = 1'b0;
               end else begin
                  valid_d[i] = 1'b0;
                  new_err    = 1'b1;
               end
            end
         end
         // Strobe already moving in the first synchroniser stage at capture time.
         if (dig_s1_q != sd)
            new_err = 1'b1;
      end
`ifdef SEVENSEG_SCAN_CAPTURE_TIMEOUT_EN
      if (tmo_hit) begin
         valid_d = '0;
         mask_d  = '0;
      end
`endif
      if (err_clr_i)
         err_d = 1'b0;
      if (new_err)
         err_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         digits_q <= '0;
         dp_q     <= '0;
         valid_q  <= '0;
         mask_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         dp_q     <= dp_d;
         valid_q  <= valid_d;
         mask_q   <= mask_d;
         err_q    <= err_d;
      end
   end

   assign digits_o = digits_q;
   assign dp_o     = dp_q;
   assign valid_o  = valid_q;
   assign frame_o  = &mask_q;
   assign err_o    = err_q;

endmodule
